// File: rtl/clock_bcd_timekeeper.sv
// BCD time-of-day keeper (HH:MM:SS) with alarm compare, W1C status and interrupt.
// Avalon-MM slave with a 4-word map: TIME, ALARM, CTRL, STATUS.
module clock_bcd_timekeeper #(
    parameter bit          HOUR_24    = 1'b1,
    parameter logic [23:0] RESET_TIME = 24'h000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        tick,
    output logic [23:0] time_out,
    output logic        alarm_out,
    output logic        irq
);

    localparam logic [1:0] ADDR_TIME   = 2'd0;
    localparam logic [1:0] ADDR_ALARM  = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    logic [23:0] time_reg;
    logic [23:0] alarm_reg;
    logic        run;
    logic        alarm_en;
    logic        irq_en;
    logic        alarm_pend;
    logic        err;

    logic        wr;
    logic        wr_time;
    logic        wr_alarm;
    logic        wr_ctrl;
    logic        wr_status;
    logic        data_legal;
    logic        advance;
    logic [23:0] next_time;
    logic        alarm_hit;

    function automatic logic time_legal(input logic [23:0] t);
        logic       ok;
        logic [7:0] hh;
        ok = (t[3:0] <= 4'd9) && (t[7:4] <= 4'd5) &&
             (t[11:8] <= 4'd9) && (t[15:12] <= 4'd5) &&
             (t[19:16] <= 4'd9);
        hh = t[23:16];
        // Digit check above already rejects x'A..x'F, so plain hex bounds suffice.
        if (HOUR_24) begin
            ok = ok && (hh <= 8'h23);
        end else begin
            ok = ok && (((hh >= 8'h01) && (hh <= 8'h09)) ||
                        ((hh >= 8'h10) && (hh <= 8'h12)));
        end
        return ok;
    endfunction

    function automatic logic [23:0] time_inc(input logic [23:0] t);
        logic [3:0] h1, h0, m1, m0, s1, s0;
        {h1, h0, m1, m0, s1, s0} = t;
        if (s0 != 4'd9) begin
            s0 = s0 + 4'd1;
        end else begin
            s0 = 4'd0;
            if (s1 != 4'd5) begin
                s1 = s1 + 4'd1;
            end else begin
                s1 = 4'd0;
                if (m0 != 4'd9) begin
                    m0 = m0 + 4'd1;
                end else begin
                    m0 = 4'd0;
                    if (m1 != 4'd5) begin
                        m1 = m1 + 4'd1;
                    end else begin
                        m1 = 4'd0;
                        if (HOUR_24 && (h1 == 4'd2) && (h0 == 4'd3)) begin
                            h1 = 4'd0;
                            h0 = 4'd0;
                        end else if (!HOUR_24 && (h1 == 4'd1) && (h0 == 4'd2)) begin
                            h1 = 4'd0;
                            h0 = 4'd1;
                        end else if (h0 == 4'd9) begin
                            h1 = h1 + 4'd1;
                            h0 = 4'd0;
                        end else begin
                            h0 = h0 + 4'd1;
                        end
                    end
                end
            end
        end
        return {h1, h0, m1, m0, s1, s0};
    endfunction

    assign wr         = chipselect & ~write_n;
    assign wr_time    = wr && (address == ADDR_TIME);
    assign wr_alarm   = wr && (address == ADDR_ALARM);
    assign wr_ctrl    = wr && (address == ADDR_CTRL);
    assign wr_status  = wr && (address == ADDR_STATUS);
    assign data_legal = time_legal(writedata[23:0]);
    assign next_time  = time_inc(time_reg);

    // A TIME write, legal or not, swallows a coincident tick.
    assign advance    = run && tick && !wr_time;
    assign alarm_hit  = advance && alarm_en && (next_time == alarm_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            time_reg   <= RESET_TIME;
            alarm_reg  <= 24'h000000;
            run        <= 1'b0;
            alarm_en   <= 1'b0;
            irq_en     <= 1'b0;
            alarm_pend <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (wr_time) begin
                if (data_legal) begin
                    time_reg <= writedata[23:0];
                end
            end else if (advance) begin
                time_reg <= next_time;
            end

            if (wr_alarm && data_legal) begin
                alarm_reg <= writedata[23:0];
            end

            if (wr_ctrl) begin
                run      <= writedata[0];
                alarm_en <= writedata[1];
                irq_en   <= writedata[2];
            end

            // Set has priority over a coincident write-1-to-clear.
            if (alarm_hit) begin
                alarm_pend <= 1'b1;
            end else if (wr_status && writedata[0]) begin
                alarm_pend <= 1'b0;
            end

            if ((wr_time || wr_alarm) && !data_legal) begin
                err <= 1'b1;
            end else if (wr_status && writedata[1]) begin
                err <= 1'b0;
            end
        end
    end

    always_comb begin
        readdata = 32'h0000_0000;
        case (address)
            ADDR_TIME:   readdata[23:0] = time_reg;
            ADDR_ALARM:  readdata[23:0] = alarm_reg;
            ADDR_CTRL:   readdata[2:0]  = {irq_en, alarm_en, run};
            ADDR_STATUS: readdata[1:0]  = {err, alarm_pend};
            default:     readdata       = 32'h0000_0000;
        endcase
    end

    assign time_out  = time_reg;
    assign alarm_out = alarm_pend;
    assign irq       = alarm_pend & irq_en;

endmodule

// File: tb/tb_clock_bcd_timekeeper.sv
// Self-checking bench for clock_bcd_timekeeper: directed scenarios on a 24h and a 12h
// instance plus a randomized run against a seconds-of-day reference model.
module tb_clock_bcd_timekeeper;

    logic        clk;
    logic        reset_n;

    logic [1:0]  address_a,    address_b;
    logic        chipselect_a, chipselect_b;
    logic        write_n_a,    write_n_b;
    logic [31:0] writedata_a,  writedata_b;
    logic [31:0] readdata_a,   readdata_b;
    logic        tick_a,       tick_b;
    logic [23:0] time_a,       time_b;
    logic        alarm_a,      alarm_b;
    logic        irq_a,        irq_b;

    int checks = 0;
    int errors = 0;

    clock_bcd_timekeeper #(.HOUR_24(1'b1), .RESET_TIME(24'h000000)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address_a), .chipselect(chipselect_a),
        .write_n(write_n_a), .writedata(writedata_a), .readdata(readdata_a),
        .tick(tick_a), .time_out(time_a), .alarm_out(alarm_a), .irq(irq_a)
    );

    clock_bcd_timekeeper #(.HOUR_24(1'b0), .RESET_TIME(24'h120000)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address_b), .chipselect(chipselect_b),
        .write_n(write_n_b), .writedata(writedata_b), .readdata(readdata_b),
        .tick(tick_b), .time_out(time_b), .alarm_out(alarm_b), .irq(irq_b)
    );

    always #5 clk = ~clk;

    // ---------------- reference helpers (seconds-of-day arithmetic) ----------------
    function automatic logic [23:0] to_bcd(input int s, input bit h24);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        if (!h24 && h == 0) h = 12;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic bit is_legal(input logic [23:0] b, input bit h24);
        int d[6];
        int hh;
        for (int i = 0; i < 6; i++) d[i] = int'(b[i*4 +: 4]);
        for (int i = 0; i < 6; i++) if (d[i] > 9) return 0;
        if (d[1] > 5 || d[3] > 5) return 0;
        hh = d[5] * 10 + d[4];
        if (h24) return hh <= 23;
        return hh >= 1 && hh <= 12;
    endfunction

    function automatic int from_bcd(input logic [23:0] b, input bit h24);
        int hh;
        hh = int'(b[23:20]) * 10 + int'(b[19:16]);
        if (!h24 && hh == 12) hh = 0;
        return hh * 3600 + (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 +
               int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    // ---------------- bus helpers ----------------
    task automatic drive(input bit d2, input logic cs, input logic wn, input logic [1:0] a,
                         input logic [31:0] d, input logic t);
        if (!d2) begin
            chipselect_a = cs; write_n_a = wn; address_a = a; writedata_a = d; tick_a = t;
        end else begin
            chipselect_b = cs; write_n_b = wn; address_b = a; writedata_b = d; tick_b = t;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit d2, input logic [1:0] a, input logic [31:0] d, input logic t);
        drive(d2, 1'b1, 1'b0, a, d, t);
        step();
        drive(d2, 1'b0, 1'b1, 2'd0, 32'h0, 1'b0);
    endtask

    task automatic ticks(input bit d2, input int n);
        repeat (n) begin
            drive(d2, 1'b0, 1'b1, 2'd0, 32'h0, 1'b1);
            step();
        end
        drive(d2, 1'b0, 1'b1, 2'd0, 32'h0, 1'b0);
    endtask

    task automatic rd(input bit d2, input logic [1:0] a, output logic [31:0] data);
        drive(d2, 1'b0, 1'b1, a, 32'h0, 1'b0);
        #1;
        data = d2 ? readdata_b : readdata_a;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 2'd0, 32'h0, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        checks++;
        if (time_a !== 24'h000000) begin
            errors++; $display("FAIL reset_time_a: got %h want 000000", time_a);
        end
        rd(1'b0, 2'd3, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL reset_status: got %h want 0", d);
        end
        checks++;
        if (irq_a !== 1'b0 || alarm_a !== 1'b0) begin
            errors++; $display("FAIL reset_irq: irq %b alarm %b want 0 0", irq_a, alarm_a);
        end
        checks++;
        if (time_b !== 24'h120000) begin
            errors++; $display("FAIL reset_time_b: got %h want 120000", time_b);
        end
    endtask

    task automatic test_count();
        logic [31:0] d;
        wr(1'b0, 2'd2, 32'h1, 1'b0);
        ticks(1'b0, 3);
        rd(1'b0, 2'd0, d);
        checks++;
        if (d !== 32'h000003) begin
            errors++; $display("FAIL count3: got %h want 000003", d);
        end
        wr(1'b0, 2'd2, 32'h0, 1'b0);
        ticks(1'b0, 2);
        checks++;
        if (time_a !== 24'h000003) begin
            errors++; $display("FAIL run_off: got %h want 000003", time_a);
        end
        wr(1'b0, 2'd2, 32'h1, 1'b0);
    endtask

    task automatic test_rollover();
        logic [23:0] starts[4] = '{24'h235959, 24'h095959, 24'h195959, 24'h005959};
        logic [23:0] want[4]   = '{24'h000000, 24'h100000, 24'h200000, 24'h010000};
        for (int i = 0; i < 4; i++) begin
            wr(1'b0, 2'd0, {8'h0, starts[i]}, 1'b0);
            ticks(1'b0, 1);
            checks++;
            if (time_a !== want[i]) begin
                errors++; $display("FAIL roll24_%0d: got %h want %h", i, time_a, want[i]);
            end
        end
    endtask

    task automatic test_12h();
        logic [23:0] starts[3] = '{24'h125959, 24'h115959, 24'h095959};
        logic [23:0] want[3]   = '{24'h010000, 24'h120000, 24'h100000};
        logic [31:0] d;
        wr(1'b1, 2'd2, 32'h1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wr(1'b1, 2'd0, {8'h0, starts[i]}, 1'b0);
            ticks(1'b1, 1);
            checks++;
            if (time_b !== want[i]) begin
                errors++; $display("FAIL roll12_%0d: got %h want %h", i, time_b, want[i]);
            end
        end
        wr(1'b1, 2'd0, 32'h000000, 1'b0);
        rd(1'b1, 2'd3, d);
        checks++;
        if (d !== 32'h2 || time_b !== 24'h100000) begin
            errors++; $display("FAIL illegal12: status %h time %h want 2 100000", d, time_b);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] d;
        wr(1'b0, 2'd0, 32'h000000, 1'b0);
        wr(1'b0, 2'd0, 32'h006000, 1'b0);
        rd(1'b0, 2'd3, d);
        checks++;
        if (time_a !== 24'h000000 || d !== 32'h2) begin
            errors++; $display("FAIL illegal_time: time %h status %h want 000000 2", time_a, d);
        end
        wr(1'b0, 2'd3, 32'h2, 1'b0);
        rd(1'b0, 2'd3, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL status_w1c_err: got %h want 0", d);
        end
        wr(1'b0, 2'd1, 32'h240000, 1'b0);
        rd(1'b0, 2'd1, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL illegal_alarm: alarm %h want 0", d);
        end
        wr(1'b0, 2'd3, 32'h2, 1'b0);
    endtask

    task automatic test_alarm();
        wr(1'b0, 2'd1, 32'h070000, 1'b0);
        wr(1'b0, 2'd2, 32'h7, 1'b0);
        wr(1'b0, 2'd0, 32'h065959, 1'b0);
        checks++;
        if (alarm_a !== 1'b0) begin
            errors++; $display("FAIL alarm_early: got %b want 0", alarm_a);
        end
        ticks(1'b0, 1);
        checks++;
        if (time_a !== 24'h070000 || alarm_a !== 1'b1 || irq_a !== 1'b1) begin
            errors++; $display("FAIL alarm_hit: time %h alarm %b irq %b want 070000 1 1",
                               time_a, alarm_a, irq_a);
        end
        ticks(1'b0, 3);
        checks++;
        if (alarm_a !== 1'b1 || irq_a !== 1'b1) begin
            errors++; $display("FAIL alarm_hold: alarm %b irq %b want 1 1", alarm_a, irq_a);
        end
        wr(1'b0, 2'd3, 32'h1, 1'b0);
        checks++;
        if (alarm_a !== 1'b0 || irq_a !== 1'b0) begin
            errors++; $display("FAIL alarm_clear: alarm %b irq %b want 0 0", alarm_a, irq_a);
        end
        // Clear racing a fresh match: the match must win.
        wr(1'b0, 2'd0, 32'h065959, 1'b0);
        wr(1'b0, 2'd3, 32'h1, 1'b1);
        checks++;
        if (alarm_a !== 1'b1) begin
            errors++; $display("FAIL clear_vs_set: alarm %b want 1", alarm_a);
        end
        wr(1'b0, 2'd2, 32'h3, 1'b0);
        checks++;
        if (irq_a !== 1'b0 || alarm_a !== 1'b1) begin
            errors++; $display("FAIL irq_en_off: irq %b alarm %b want 0 1", irq_a, alarm_a);
        end
        wr(1'b0, 2'd3, 32'h1, 1'b0);
        wr(1'b0, 2'd2, 32'h7, 1'b0);
    endtask

    task automatic test_collision();
        wr(1'b0, 2'd0, 32'h115959, 1'b0);
        wr(1'b0, 2'd0, 32'h120000, 1'b1);
        checks++;
        if (time_a !== 24'h120000) begin
            errors++; $display("FAIL write_vs_tick: got %h want 120000", time_a);
        end
        wr(1'b0, 2'd0, 32'h126000, 1'b1);
        checks++;
        if (time_a !== 24'h120000) begin
            errors++; $display("FAIL illegal_vs_tick: got %h want 120000", time_a);
        end
        wr(1'b0, 2'd3, 32'h2, 1'b0);
        wr(1'b0, 2'd0, 32'h070000, 1'b0);
        checks++;
        if (alarm_a !== 1'b0) begin
            errors++; $display("FAIL sw_time_eq_alarm: alarm %b want 0", alarm_a);
        end
        wr(1'b0, 2'd1, 32'h070001, 1'b0);
        wr(1'b0, 2'd1, 32'h070000, 1'b0);
        checks++;
        if (alarm_a !== 1'b0) begin
            errors++; $display("FAIL sw_alarm_eq_time: alarm %b want 0", alarm_a);
        end
    endtask

    task automatic test_random();
        int          t_s;
        logic [23:0] m_alarm;
        bit          m_run, m_aen, m_ien, m_pend, m_err, set;
        int          r;
        logic [1:0]  a;
        logic [31:0] d, exp_rd;
        logic        tk, cs;
        do_reset();
        t_s = 0; m_alarm = 24'h0;
        m_run = 0; m_aen = 0; m_ien = 0; m_pend = 0; m_err = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r  = int'($urandom_range(0, 99));
            tk = ($urandom_range(0, 9) < 6);
            cs = 1'b1;
            a  = 2'($urandom_range(0, 3));
            d  = $urandom;
            if (r < 8) begin
                a = 2'd0; d = {8'h0, to_bcd(int'($urandom_range(0, 86399)), 1'b1)};
            end else if (r < 11) begin
                a = 2'd0; d = $urandom & 32'h00FF_FFFF;
            end else if (r < 17) begin
                a = 2'd1; d = {8'h0, to_bcd((t_s + int'($urandom_range(1, 4))) % 86400, 1'b1)};
            end else if (r < 19) begin
                a = 2'd1;
            end else if (r < 23) begin
                a = 2'd2; d = {29'h0, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0)};
            end else if (r < 27) begin
                a = 2'd3;
            end else begin
                cs = 1'b0;
            end
            drive(1'b0, cs, ~cs, a, d, tk);
            #1;
            if (!cs) begin
                case (a)
                    2'd0:    exp_rd = {8'h0, to_bcd(t_s, 1'b1)};
                    2'd1:    exp_rd = {8'h0, m_alarm};
                    2'd2:    exp_rd = {29'h0, m_ien, m_aen, m_run};
                    default: exp_rd = {30'h0, m_err, m_pend};
                endcase
                checks++;
                if (readdata_a !== exp_rd) begin
                    errors++; $display("FAIL rand_read cyc %0d addr %0d: got %h want %h",
                                       cyc, a, readdata_a, exp_rd);
                end
            end
            @(posedge clk);
            set = 0;
            if (cs && a == 2'd0) begin
                if (is_legal(d[23:0], 1'b1)) t_s = from_bcd(d[23:0], 1'b1);
                else m_err = 1;
            end else if (tk && m_run) begin
                t_s = (t_s + 1) % 86400;
                if (m_aen && to_bcd(t_s, 1'b1) == m_alarm) set = 1;
            end
            if (cs && a == 2'd1) begin
                if (is_legal(d[23:0], 1'b1)) m_alarm = d[23:0];
                else m_err = 1;
            end
            if (cs && a == 2'd2) begin
                m_run = d[0]; m_aen = d[1]; m_ien = d[2];
            end
            if (cs && a == 2'd3) begin
                if (d[0]) m_pend = 0;
                if (d[1]) m_err = 0;
            end
            if (set) m_pend = 1;
            #1;
            checks++;
            if (time_a !== to_bcd(t_s, 1'b1) || alarm_a !== m_pend || irq_a !== (m_pend & m_ien)) begin
                errors++; $display("FAIL rand_state cyc %0d: time %h alarm %b irq %b want %h %b %b",
                                   cyc, time_a, alarm_a, irq_a, to_bcd(t_s, 1'b1), m_pend,
                                   m_pend & m_ien);
            end
        end
        drive(1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 1'b0);
    endtask

    task automatic test_async_reset();
        wr(1'b0, 2'd1, 32'h123457, 1'b0);
        wr(1'b0, 2'd2, 32'h7, 1'b0);
        wr(1'b0, 2'd0, 32'h123456, 1'b0);
        ticks(1'b0, 1);
        checks++;
        if (irq_a !== 1'b1 || time_a !== 24'h123457) begin
            errors++; $display("FAIL pre_reset: irq %b time %h want 1 123457", irq_a, time_a);
        end
        wr(1'b1, 2'd0, 32'h034500, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 2'd2, 32'h0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (time_a !== 24'h000000 || alarm_a !== 1'b0 || irq_a !== 1'b0 ||
            readdata_a !== 32'h0 || time_b !== 24'h120000) begin
            errors++; $display("FAIL async_reset: time %h alarm %b irq %b ctrl %h time_b %h want 000000 0 0 0 120000",
                               time_a, alarm_a, irq_a, readdata_a, time_b);
        end
        step();
        checks++;
        if (time_a !== 24'h000000) begin
            errors++; $display("FAIL reset_hold: time %h want 000000", time_a);
        end
        drive(1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        clk = 1'b0;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 2'd0, 32'h0, 1'b0);
        test_reset();
        test_count();
        test_rollover();
        test_12h();
        test_illegal();
        test_alarm();
        test_collision();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_bcd_timekeeper.md
Name: clock_bcd_timekeeper

Overview:
Parametrised Avalon-MM slave timekeeping block. It replaces the per-digit 8-bit output registers with a single BCD time-of-day counter (HH:MM:SS), an alarm comparator and an interrupt. The counter advances on an external 1 Hz tick pulse. Software reads and writes time, alarm and control through a 4-word register map. The digit outputs drive the display decoders directly.

Parameters:
HOUR_24, 1, 1 = 24-hour mode (00..23); 0 = 12-hour mode (01..12, no AM/PM bit)
RESET_TIME, 24'h000000, BCD time loaded at reset; must be a legal time for the selected HOUR_24 mode (use 24'h120000 when HOUR_24=0)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, combinational, zero wait states
tick  in  1  1-cycle pulse, one per second, synchronous to clk
time_out  out  24  {H1,H0,M1,M0,S1,S0}, 4-bit BCD each
alarm_out  out  1  level copy of STATUS.ALARM_PEND
irq  out  1  ALARM_PEND & CTRL.IRQ_EN

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk. All state updates on posedge clk.
- Register map (wr = chipselect & ~write_n):
  - 0 TIME: [23:0] RW, BCD time.
  - 1 ALARM: [23:0] RW, BCD alarm time.
  - 2 CTRL: bit0 RUN, bit1 ALARM_EN, bit2 IRQ_EN; RW.
  - 3 STATUS: bit0 ALARM_PEND, bit1 ERR; write-1-to-clear.
- Unused readdata bits read 0. Reads have no side effects.
- Reset values: TIME = RESET_TIME; ALARM = 0; CTRL = 0; STATUS = 0. Hence time_out = RESET_TIME and alarm_out = irq = 0.
- Write legality: each BCD digit ≤ 9; S1 and M1 ≤ 5; hours 00..23 (HOUR_24=1) or 01..12 (HOUR_24=0).
  - A legal write to TIME or ALARM updates the register next cycle.
  - An illegal write leaves the register unchanged and sets ERR.
- Increment: when RUN=1 and tick=1, TIME advances by 1 s in one cycle with cascaded BCD carries:
  - S0 9→0 carries to S1; S1 5→0 carries to M0; M0 9→0 carries to M1; M1 5→0 carries to hours.
  - Hours, 24h mode: 09→10, 19→20, 23→00.
  - Hours, 12h mode: 09→10, 12→01.
  - tick with RUN=0 is ignored. Ticks are not queued.
- Simultaneous events:
  - TIME write in the same cycle as tick: the write wins and the tick is dropped. This holds even if the write is illegal.
  - W1C of ALARM_PEND in the same cycle as a new alarm match: the set wins and ALARM_PEND stays 1.
- Alarm:
  - Trigger: a tick-driven increment that produces next_time == ALARM while ALARM_EN=1.
  - ALARM_PEND goes to 1 on the same edge that TIME takes the matching value.
  - Edge-triggered: no re-trigger while TIME stays equal to ALARM.
  - Software writes to TIME or ALARM never trigger the alarm.
- ALARM_PEND remains 1 until cleared by W1C or reset. Clearing ALARM_EN does not clear it.
- irq is combinational from the registered ALARM_PEND and IRQ_EN; no extra latency.
- Asynchronous reset mid-increment or mid-write: all registers return to their reset values immediately. No partial update is visible.

Test Plan:
- Reset with HOUR_24=1 -> time_out=24'h000000, readdata at addr 3 = 0, irq=0. Write CTRL=1, then 3 ticks -> TIME reads 24'h000003.
- TIME=24'h235959, RUN=1, 1 tick -> 24'h000000. TIME=24'h095959, 1 tick -> 24'h100000. HOUR_24=0 instance: 24'h125959 -> 24'h010000.
- Write TIME=24'h006000 -> TIME unchanged, STATUS=2'b10. Write STATUS=2 -> STATUS=0.
- ALARM=24'h070000, CTRL=3'b111, TIME=24'h065959, tick -> on that edge TIME=24'h070000, alarm_out=1, irq=1. Further ticks keep both at 1. W1C STATUS=1 -> both 0.
- TIME write of 24'h120000 in the same cycle as tick -> TIME=24'h120000 (no +1). Software write TIME=ALARM -> ALARM_PEND stays 0.
- Assert reset_n=0 during a tick with RUN=1 -> outputs return to reset values asynchronously, before the next clk edge.
